// File: rtl/sect233k1_pkg.sv
// Shared definitions for the sect233k1 blocks: field size, reduction polynomial,
// generator point, checker FSM states and the multiply-by-z^n helper.
package sect233k1_pkg;

    localparam int M_BITS = 233;
    localparam int POLY_K = 74;

    localparam logic [M_BITS-1:0] GX = 233'h17232ba853a7e731af129f22ff4149563a419c26bf50a4c9d6eefad6126;
    localparam logic [M_BITS-1:0] GY = 233'h1db537dece819b7f70f555a67c427a8cd9bf18aeb9b56e0c11056fae6a3;

    typedef enum logic [2:0] {
        IDLE,
        MUL1,
        MUL2,
        MUL3,
        FIN
    } state_t;

    // Multiplies a by z^n and reduces by f(z) = z^233 + z^74 + 1, one bit at a time.
    function automatic logic [M_BITS-1:0] mulz_mod(input logic [M_BITS-1:0] a, input int n);
        logic [M_BITS-1:0] r;
        logic              carry;
        r = a;
        for (int i = 0; i < M_BITS; i++) begin
            if (i < n) begin
                carry     = r[M_BITS-1];
                r         = {r[M_BITS-2:0], 1'b0};
                r[0]      = r[0] ^ carry;
                r[POLY_K] = r[POLY_K] ^ carry;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/sect233k1_gf_mul_ds.sv
// MSB-first digit-serial GF(2^233) multiplier: c = a*b mod f in M = ceil(233/Digit) cycles.
// The first digit is consumed on the start edge, so done is high in the cycle after edge start+M-1.
module sect233k1_gf_mul_ds
    import sect233k1_pkg::*;
#(
    parameter int Digit = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              start,
    input  logic [M_BITS-1:0] a,
    input  logic [M_BITS-1:0] b,
    output logic              done,
    output logic [M_BITS-1:0] c
);

    localparam int M  = (M_BITS + Digit - 1) / Digit;
    localparam int W  = M * Digit;
    localparam int CW = $clog2(M + 1);

    logic [M_BITS-1:0] r_a;
    logic [M_BITS-1:0] r_acc;
    logic [W-1:0]      r_b;
    logic [CW-1:0]     r_cnt;
    logic              r_busy;
    logic [W-1:0]      w_b_pad;
    logic              w_done;

    // acc*z^Digit + a*d, folded bit by bit so every partial stays reduced.
    function automatic logic [M_BITS-1:0] step(input logic [M_BITS-1:0] acc,
                                               input logic [M_BITS-1:0] op_a,
                                               input logic [Digit-1:0]  d);
        logic [M_BITS-1:0] t;
        t = acc;
        for (int i = Digit - 1; i >= 0; i--) begin
            t = mulz_mod(t, 1) ^ ({M_BITS{d[i]}} & op_a);
        end
        return t;
    endfunction

    always_comb begin
        w_b_pad             = '0;
        w_b_pad[M_BITS-1:0] = b;
    end

    assign w_done = r_busy && (r_cnt == CW'(M));
    assign done   = w_done;
    assign c      = r_acc;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a    <= '0;
            r_acc  <= '0;
            r_b    <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
        end else if (clr) begin
            r_a    <= '0;
            r_acc  <= '0;
            r_b    <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
        end else if (start) begin
            r_a    <= a;
            r_acc  <= step('0, a, w_b_pad[W-1 -: Digit]);
            r_b    <= w_b_pad << Digit;
            r_cnt  <= CW'(1);
            r_busy <= 1'b1;
        end else if (r_busy) begin
            if (w_done) begin
                r_busy <= 1'b0;
            end else begin
                r_acc <= step(r_acc, r_a, r_b[W-1 -: Digit]);
                r_b   <= r_b << Digit;
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/sect233k1_pt_check.sv
// Checks y^2 + x*y == x^3 + 1 over GF(2^233) for an affine point, (0,0) counting as infinity.
// One shared digit-serial multiplier computes y*(x^y), x*x and (x*x)*x back to back.
module sect233k1_pt_check
    import sect233k1_pkg::*;
#(
    parameter int Digit = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              start,
    input  logic [M_BITS-1:0] x,
    input  logic [M_BITS-1:0] y,
    output logic              done,
    output logic              valid
);

    state_t            r_state;
    state_t            w_next;
    logic [M_BITS-1:0] r_x;
    logic [M_BITS-1:0] r_y;
    logic [M_BITS-1:0] r_t1;
    logic              r_done;
    logic              r_valid;

    logic              w_mul_start;
    logic [M_BITS-1:0] w_mul_a;
    logic [M_BITS-1:0] w_mul_b;
    logic              w_mul_done;
    logic [M_BITS-1:0] w_mul_c;
    logic [M_BITS-1:0] w_r;
    logic              w_fin_valid;

    sect233k1_gf_mul_ds #(.Digit(Digit)) u_mul (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .start (w_mul_start),
        .a     (w_mul_a),
        .b     (w_mul_b),
        .done  (w_mul_done),
        .c     (w_mul_c)
    );

    // The next product starts on the edge the previous one completes; MUL3 takes t2 straight
    // from the multiplier accumulator, which still holds it on that edge.
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can infer a latch.
        w_next      = r_state;
        w_mul_start = 1'b0;
        w_mul_a     = r_x;
        w_mul_b     = r_x;
        case (r_state)
            IDLE: if (start) begin
                w_next      = MUL1;
                w_mul_start = 1'b1;
                w_mul_a     = y;
                w_mul_b     = x ^ y;
            end
            MUL1: if (w_mul_done) begin
                w_next      = MUL2;
                w_mul_start = 1'b1;
            end
            MUL2: if (w_mul_done) begin
                w_next      = MUL3;
                w_mul_start = 1'b1;
                w_mul_b     = w_mul_c;
            end
            MUL3: if (w_mul_done) w_next = FIN;
            FIN:  w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    assign w_r         = r_t1 ^ w_mul_c ^ M_BITS'(1);
    assign w_fin_valid = (w_r == '0) || ((r_x == '0) && (r_y == '0));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_x     <= '0;
            r_y     <= '0;
            r_t1    <= '0;
            r_done  <= 1'b0;
            r_valid <= 1'b0;
        end else if (clr) begin
            r_state <= IDLE;
            r_x     <= '0;
            r_y     <= '0;
            r_t1    <= '0;
            r_done  <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_next;
            r_done  <= (r_state == FIN);
            if (r_state == IDLE && start) begin
                r_x     <= x;
                r_y     <= y;
                r_valid <= 1'b0;
            end
            if (r_state == MUL1 && w_mul_done) r_t1 <= w_mul_c;
            if (r_state == FIN) r_valid <= w_fin_valid;
        end
    end

    assign done  = r_done;
    assign valid = r_valid;

endmodule
